// File: rtl/hazard_unit.sv
// hazard_unit: pipeline hazard control for a 5-stage in-order core.
// Computes EX-stage operand forwarding selects, detects load-use hazards,
// handles taken-branch flushes and, when the HAZARD_MDU_EN macro is defined,
// sequences multi-cycle mul/div operations with an IDLE/BUSY/DONE FSM that
// holds the front of the pipeline while the operation runs.
// Priority of pipeline control: taken branch, then MDU stall, then load-use.
module hazard_unit #(
    parameter int         MDU_LATENCY = 32,
    parameter logic [1:0] LOAD_SRC    = 2'b01
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [4:0] rs1_d,
    input  logic [4:0] rs2_d,
    input  logic [4:0] rs1_e,
    input  logic [4:0] rs2_e,
    input  logic [4:0] rd_e,
    input  logic       rd_write_e,
    input  logic [1:0] rd_write_src_e,
    input  logic [4:0] rd_m,
    input  logic [4:0] rd_w,
    input  logic       rd_write_m,
    input  logic       rd_write_w,
    input  logic       branch_taken_e,
    input  logic       mdu_start_e,
    output logic [1:0] forwarding_rs1_e,
    output logic [1:0] forwarding_rs2_e,
    output logic       stall_f,
    output logic       stall_d,
    output logic       stall_e,
    output logic       flush_d,
    output logic       flush_e,
    output logic       flush_m,
    output logic       mdu_busy,
    output logic       mdu_done
);

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

    logic load_use;
    logic mdu_stall;

    // Forwarding selects: the youngest producer (memory stage) wins; x0 is never forwarded.
    always_comb begin
        forwarding_rs1_e = FWD_RF;
        forwarding_rs2_e = FWD_RF;
        if (rd_write_m && (rd_m != 5'd0) && (rd_m == rs1_e))
            forwarding_rs1_e = FWD_MEM;
        else if (rd_write_w && (rd_w != 5'd0) && (rd_w == rs1_e))
            forwarding_rs1_e = FWD_WB;
        if (rd_write_m && (rd_m != 5'd0) && (rd_m == rs2_e))
            forwarding_rs2_e = FWD_MEM;
        else if (rd_write_w && (rd_w != 5'd0) && (rd_w == rs2_e))
            forwarding_rs2_e = FWD_WB;
    end

    assign load_use = rd_write_e && (rd_write_src_e == LOAD_SRC) && (rd_e != 5'd0) &&
                      ((rd_e == rs1_d) || (rd_e == rs2_d));

`ifdef HAZARD_MDU_EN
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        BUSY = 2'b01,
        DONE = 2'b10
    } mdu_state_t;

    localparam logic [5:0] MDU_LAT6 = 6'(MDU_LATENCY);

    mdu_state_t state;
    logic [5:0] cnt;
    logic       busy_q;
    logic       done_q;

    // MDU sequencer: count down the operation latency, then pulse done for one cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            cnt    <= 6'd0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (mdu_start_e && !branch_taken_e) begin
                        state  <= BUSY;
                        cnt    <= MDU_LAT6;
                        busy_q <= 1'b1;
                    end
                end
                BUSY: begin
                    cnt <= cnt - 6'd1;
                    if (cnt == 6'd1) begin
                        state  <= DONE;
                        done_q <= 1'b1;
                    end
                end
                DONE: begin
                    state  <= IDLE;
                    busy_q <= 1'b0;
                    done_q <= 1'b0;
                end
                default: begin
                    state  <= IDLE;
                    cnt    <= 6'd0;
                    busy_q <= 1'b0;
                    done_q <= 1'b0;
                end
            endcase
        end
    end

    // The start cycle itself already stalls so the operation never leaves execute early.
    assign mdu_stall = ((state == IDLE) && mdu_start_e && !branch_taken_e) || (state == BUSY);
    assign mdu_busy  = busy_q;
    assign mdu_done  = done_q;
`else
    logic unused_mdu;

    assign unused_mdu = ^{clk, rst_n, mdu_start_e, 6'(MDU_LATENCY)};
    assign mdu_stall  = 1'b0;
    assign mdu_busy   = 1'b0;
    assign mdu_done   = 1'b0;
`endif

    // Pipeline control: branch redirect beats an MDU hold, which beats a load-use bubble.
    always_comb begin
        stall_f = 1'b0;
        stall_d = 1'b0;
        stall_e = 1'b0;
        flush_d = 1'b0;
        flush_e = 1'b0;
        flush_m = 1'b0;
        if (branch_taken_e) begin
            flush_d = 1'b1;
            flush_e = 1'b1;
        end else if (mdu_stall) begin
            // Execute is held, so memory receives a bubble; flush_e stays low to keep the op.
            stall_f = 1'b1;
            stall_d = 1'b1;
            stall_e = 1'b1;
            flush_m = 1'b1;
        end else if (load_use) begin
            stall_f = 1'b1;
            stall_d = 1'b1;
            flush_e = 1'b1;
        end
    end

endmodule

// File: tb/tb_hazard_unit.sv
// tb_hazard_unit: directed-vector bench for hazard_unit (MDU_LATENCY = 4).
// MDU sequencing vectors run when HAZARD_MDU_EN is defined; otherwise the
// disabled-build behaviour is checked instead.
module tb_hazard_unit;

    logic       clk;
    logic       rst_n;
    logic [4:0] rs1_d, rs2_d, rs1_e, rs2_e, rd_e, rd_m, rd_w;
    logic       rd_write_e, rd_write_m, rd_write_w;
    logic [1:0] rd_write_src_e;
    logic       branch_taken_e, mdu_start_e;
    logic [1:0] forwarding_rs1_e, forwarding_rs2_e;
    logic       stall_f, stall_d, stall_e, flush_d, flush_e, flush_m, mdu_busy, mdu_done;

    int n_vec  = 0;
    int n_miss = 0;

    hazard_unit #(
        .MDU_LATENCY (4),
        .LOAD_SRC    (2'b01)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .rs1_d            (rs1_d),
        .rs2_d            (rs2_d),
        .rs1_e            (rs1_e),
        .rs2_e            (rs2_e),
        .rd_e             (rd_e),
        .rd_write_e       (rd_write_e),
        .rd_write_src_e   (rd_write_src_e),
        .rd_m             (rd_m),
        .rd_w             (rd_w),
        .rd_write_m       (rd_write_m),
        .rd_write_w       (rd_write_w),
        .branch_taken_e   (branch_taken_e),
        .mdu_start_e      (mdu_start_e),
        .forwarding_rs1_e (forwarding_rs1_e),
        .forwarding_rs2_e (forwarding_rs2_e),
        .stall_f          (stall_f),
        .stall_d          (stall_d),
        .stall_e          (stall_e),
        .flush_d          (flush_d),
        .flush_e          (flush_e),
        .flush_m          (flush_m),
        .mdu_busy         (mdu_busy),
        .mdu_done         (mdu_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Packs the six pipeline-control outputs as {stall_f,stall_d,stall_e,flush_d,flush_e,flush_m}.
    function automatic logic [7:0] ctl();
        return {2'b00, stall_f, stall_d, stall_e, flush_d, flush_e, flush_m};
    endfunction

    task automatic clear_inputs();
        rs1_d = 0; rs2_d = 0; rs1_e = 0; rs2_e = 0; rd_e = 0; rd_m = 0; rd_w = 0;
        rd_write_e = 0; rd_write_m = 0; rd_write_w = 0; rd_write_src_e = 2'b00;
        branch_taken_e = 0; mdu_start_e = 0;
    endtask

    // Advance to the next falling edge (inputs change here, outputs sampled 1 time unit later).
    task automatic next_cyc();
        @(negedge clk);
    endtask

    initial begin
        int stall_cnt;
        clear_inputs();
        rst_n = 1'b0;
        #2;
        chk("rst_busy",  {7'd0, mdu_busy}, 8'h00);
        chk("rst_done",  {7'd0, mdu_done}, 8'h00);
        chk("rst_ctl",   ctl(), 8'h00);
        rd_m = 5; rd_write_m = 1; rs1_e = 5;
        #1;
        chk("rst_fwd_follows", {6'd0, forwarding_rs1_e}, 8'h02);
        clear_inputs();
        next_cyc();
        next_cyc();
        rst_n = 1'b1;

        // Forwarding vectors
        next_cyc();
        rd_m = 5; rd_write_m = 1; rd_w = 5; rd_write_w = 1; rs1_e = 5; rs2_e = 0;
        #1;
        chk("fwd_mem_prio", {6'd0, forwarding_rs1_e}, 8'h02);
        chk("fwd_rs2_none", {6'd0, forwarding_rs2_e}, 8'h00);
        rd_m = 0;
        #1;
        chk("fwd_wb_rdm0", {6'd0, forwarding_rs1_e}, 8'h01);
        rd_m = 7; rd_w = 9; rs1_e = 9; rs2_e = 7;
        #1;
        chk("fwd_rs1_wb", {6'd0, forwarding_rs1_e}, 8'h01);
        chk("fwd_rs2_mem", {6'd0, forwarding_rs2_e}, 8'h02);
        rd_write_m = 0;
        #1;
        chk("fwd_rs2_wm0", {6'd0, forwarding_rs2_e}, 8'h00);
        rd_w = 0; rs1_e = 0;
        #1;
        chk("fwd_x0", {6'd0, forwarding_rs1_e}, 8'h00);
        rd_w = 9; rs1_e = 9; rd_write_w = 0;
        #1;
        chk("fwd_ww0", {6'd0, forwarding_rs1_e}, 8'h00);
        chk("fwd_ctl_idle", ctl(), 8'h00);
        clear_inputs();

        // Load-use vectors
        next_cyc();
        rd_e = 3; rd_write_e = 1; rd_write_src_e = 2'b01; rs2_d = 3;
        #1;
        chk("lu_stall", ctl(), 8'h32);
        next_cyc();
        rd_write_e = 0; rd_e = 0;
        #1;
        chk("lu_bubble", ctl(), 8'h00);
        rd_e = 3; rd_write_e = 1; rd_write_src_e = 2'b10;
        #1;
        chk("lu_not_load", ctl(), 8'h00);
        rd_e = 0; rd_write_src_e = 2'b01; rs1_d = 0; rs2_d = 0;
        #1;
        chk("lu_x0", ctl(), 8'h00);
        rd_e = 4; rs1_d = 4;
        #1;
        chk("lu_rs1", ctl(), 8'h32);
        branch_taken_e = 1;
        #1;
        chk("lu_branch", ctl(), 8'h06);
        clear_inputs();

`ifdef HAZARD_MDU_EN
        // One-shot MDU op, issued together with a load-use hazard that must not kill it
        next_cyc();
        mdu_start_e = 1; rd_e = 3; rd_write_e = 1; rd_write_src_e = 2'b01; rs1_d = 3;
        #1;
        chk("mdu_start_ctl", ctl(), 8'h39);
        chk("mdu_start_busy", {7'd0, mdu_busy}, 8'h00);
        next_cyc();
        clear_inputs();
        for (int i = 0; i < 4; i++) begin
            #1;
            chk($sformatf("mdu_busy_ctl%0d", i), ctl(), 8'h39);
            chk($sformatf("mdu_busy_flag%0d", i), {6'd0, mdu_busy, mdu_done}, 8'h02);
            next_cyc();
        end
        #1;
        chk("mdu_done_ctl", ctl(), 8'h00);
        chk("mdu_done_flag", {6'd0, mdu_busy, mdu_done}, 8'h03);
        next_cyc();
        #1;
        chk("mdu_idle_flag", {6'd0, mdu_busy, mdu_done}, 8'h00);

        // Start suppressed by a taken branch
        mdu_start_e = 1; branch_taken_e = 1;
        #1;
        chk("mdu_br_ctl", ctl(), 8'h06);
        next_cyc();
        clear_inputs();
        #1;
        chk("mdu_br_nostart", {6'd0, mdu_busy, mdu_done}, 8'h00);

        // Abort mid-BUSY by reset, then a full-latency restart
        mdu_start_e = 1;
        next_cyc();
        mdu_start_e = 0;
        next_cyc();
        next_cyc();
        rst_n = 1'b0;
        #1;
        chk("abort_busy", {6'd0, mdu_busy, mdu_done}, 8'h00);
        chk("abort_ctl", ctl(), 8'h00);
        next_cyc();
        #1;
        chk("abort_nodone", {6'd0, mdu_busy, mdu_done}, 8'h00);
        rst_n = 1'b1;
        next_cyc();
        mdu_start_e = 1;
        stall_cnt = 0;
        #1;
        while (stall_e && stall_cnt < 20) begin
            stall_cnt++;
            next_cyc();
            mdu_start_e = 0;
            #1;
        end
        chk("restart_stall_len", 8'(stall_cnt), 8'd5);
        chk("restart_done", {7'd0, mdu_done}, 8'h01);
        next_cyc();
`else
        // Disabled build: start is ignored, forwarding still works
        next_cyc();
        mdu_start_e = 1; rd_m = 6; rd_write_m = 1; rs2_e = 6;
        #1;
        chk("nomdu_ctl", ctl(), 8'h00);
        chk("nomdu_fwd", {6'd0, forwarding_rs2_e}, 8'h02);
        for (int i = 0; i < 3; i++) begin
            next_cyc();
            #1;
            chk($sformatf("nomdu_flag%0d", i), {6'd0, mdu_busy, mdu_done}, 8'h00);
            chk($sformatf("nomdu_stall%0d", i), {7'd0, stall_e}, 8'h00);
        end
        clear_inputs();
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
